apb_gpio_arbiter: RTL and testbench

//   Two-requester APB master that shares the GPIO APB slave (apb_top) between

---
 rtl/apb_gpio_arbiter.sv | 155 +++++++++++++++
 tb/tb_apb_gpio_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_gpio_arbiter.sv
// Two-requester APB master sharing one GPIO APB slave between independent agents.
// Round-robin arbitration, SETUP/ACCESS transfers, PREADY waits, optional hung-transfer abort.
module apb_gpio_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic            PCLK,
  input  logic            PRESETn,
  input  logic [1:0]      req,
  input  logic [1:0]      wr,
  input  logic [2*AW-1:0] addr,
  input  logic [2*DW-1:0] wdata,
  output logic [1:0]      done,
  output logic [1:0]      err,
  output logic [DW-1:0]   rdata,
  output logic            busy,
  output logic            PSEL,
  output logic            PENABLE,
  output logic            PWRITE,
  output logic [AW-1:0]   PADDR,
  output logic [DW-1:0]   PWDATA,
  input  logic [DW-1:0]   PRDATA,
  input  logic            PREADY
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CntMax   = '1;
  localparam logic [CW-1:0] CntLimit = CW'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e          state_q, state_d;
  logic            psel_q, psel_d;
  logic            penable_q, penable_d;
  logic            pwrite_q, pwrite_d;
  logic [AW-1:0]   paddr_q, paddr_d;
  logic [DW-1:0]   pwdata_q, pwdata_d;
  logic [1:0]      done_q, done_d;
  logic [1:0]      err_q, err_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            busy_q, busy_d;
  logic            last_q, last_d;
  logic            gnt_q, gnt_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      eligible;
  logic            sel;
  logic [CW-1:0]   cnt_inc;

  always_comb begin
    state_d   = state_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    done_d    = 2'b00;
    err_d     = 2'b00;
    rdata_d   = rdata_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    cnt_d     = cnt_q;
    sel       = 1'b0;
    // A requester is held off during its own done cycle so the other side gets a turn.
    eligible  = req & ~done_q;
    cnt_inc   = (cnt_q == CntMax) ? cnt_q : cnt_q + CW'(1);

    unique case (state_q)
      StIdle: begin
        if (eligible != 2'b00) begin
          sel       = (eligible == 2'b11) ? ~last_q : eligible[1];
          gnt_d     = sel;
          paddr_d   = sel ? addr[2*AW-1:AW]  : addr[AW-1:0];
          pwdata_d  = sel ? wdata[2*DW-1:DW] : wdata[DW-1:0];
          pwrite_d  = wr[sel];
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = StSetup;
        end
      end
      StSetup: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = StAccess;
      end
      StAccess: begin
        if (PREADY) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          done_d[gnt_q] = 1'b1;
          if (!pwrite_q) rdata_d = PRDATA;
          last_d        = gnt_q;
          state_d       = StIdle;
        end else begin
          cnt_d = cnt_inc;
          if ((TIMEOUT != 0) && (cnt_inc == CntLimit)) begin
            psel_d        = 1'b0;
            penable_d     = 1'b0;
            done_d[gnt_q] = 1'b1;
            err_d[gnt_q]  = 1'b1;
            rdata_d       = '0;
            last_d        = gnt_q;
            state_d       = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= StIdle;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      done_q    <= 2'b00;
      err_q     <= 2'b00;
      rdata_q   <= '0;
      busy_q    <= 1'b0;
      last_q    <= 1'b1;
      gnt_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      busy_q    <= busy_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      cnt_q     <= cnt_d;
    end
  end

  assign done    = done_q;
  assign err     = err_q;
  assign rdata   = rdata_q;
  assign busy    = busy_q;
  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign PWRITE  = pwrite_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;

endmodule

// File: tb/tb_apb_gpio_arbiter.sv
// Bench for apb_gpio_arbiter: directed transfers against a small GPIO slave model,
// completions checked by a scoreboard monitor, APB timing checked inline.
module tb_apb_gpio_arbiter;

  localparam logic [31:0] AddrIn  = 32'h0000_0000;
  localparam logic [31:0] AddrOut = 32'h0000_0004;
  localparam logic [31:0] AddrOe  = 32'h0000_0008;
  localparam logic [31:0] InVal   = 32'habfe_fabe;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic [1:0]  req, wr, done, err;
  logic [63:0] addr, wdata;
  logic [31:0] rdata, PADDR, PWDATA, PRDATA;
  logic        busy, PSEL, PENABLE, PWRITE, PREADY;

  apb_gpio_arbiter #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .done(done), .err(err), .rdata(rdata), .busy(busy), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  // Slave model: RGPIO_IN is a fixed input value, other registers are plain storage.
  logic [31:0] mem [16];
  int          acc_cnt = 0;
  int          waits = 0;
  bit          hang = 1'b0;

  always_comb begin
    PRDATA = (PADDR[5:2] == 4'd0) ? InVal : mem[PADDR[5:2]];
    PREADY = hang ? 1'b0 : (acc_cnt >= waits);
  end

  always @(posedge PCLK) begin
    if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
    if (PSEL && PENABLE && PREADY && PWRITE) mem[PADDR[5:2]] <= PWDATA;
  end

  typedef struct {
    logic [1:0]  done;
    logic [1:0]  err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] model_rdata = '0;
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected completion for a normal transfer; writes leave rdata untouched.
  task automatic push_ok(input int i, input logic w, input logic [31:0] rd);
    exp_t e;
    e.done = 2'b00;
    e.done[i] = 1'b1;
    e.err = 2'b00;
    if (!w) model_rdata = rd;
    e.rdata = model_rdata;
    sb.push_back(e);
  endtask

  task automatic push_err(input int i);
    exp_t e;
    e.done = 2'b00;
    e.done[i] = 1'b1;
    e.err = e.done;
    model_rdata = '0;
    e.rdata = '0;
    sb.push_back(e);
  endtask

  task automatic issue(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
    wr[i] = w;
    addr[i*32 +: 32] = a;
    wdata[i*32 +: 32] = d;
    req[i] = 1'b1;
  endtask

  task automatic wait_done(input int i, input bit drop);
    bit seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge PCLK);
      if (done[i]) seen = 1'b1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL wait_done%0d: got no done pulse expected one within 200 cycles", i);
    end
    if (drop) req[i] = 1'b0;
  endtask

  // Follows one transfer through ACCESS, checking the APB outputs stay put.
  task automatic watch(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input int exp_n, input string tag);
    int n = 0;
    bit fin = 1'b0;
    for (int k = 0; k < 100 && !fin; k++) begin
      @(negedge PCLK);
      if (PENABLE) begin
        n++;
        check({tag, "_psel"}, PSEL, 1);
        check({tag, "_paddr"}, PADDR, a);
        check({tag, "_pwrite"}, PWRITE, w);
        if (w) check({tag, "_pwdata"}, PWDATA, d);
      end else if (n > 0) begin
        fin = 1'b1;
      end
    end
    check({tag, "_access_cycles"}, n, exp_n);
    check({tag, "_done"}, done[i], 1);
    check({tag, "_psel_drop"}, PSEL, 0);
    req[i] = 1'b0;
  endtask

  always @(negedge PCLK) begin
    if (PRESETn && done != 2'b00) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got done=%b expected no completion", done);
      end else begin
        mon_e = sb.pop_front();
        check("sb_done", done, mon_e.done);
        check("sb_err", err, mon_e.err);
        check("sb_rdata", rdata, mon_e.rdata);
      end
    end
  end

  initial begin
    PRESETn = 1'b0;
    req = '0; wr = '0; addr = '0; wdata = '0;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    check("rst_psel", PSEL, 0);
    check("rst_penable", PENABLE, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_rdata", rdata, 0);
    check("rst_paddr", PADDR, 0);
    PRESETn = 1'b1;

    // 1: m0 write OE, exact zero-wait latency, then readback.
    @(posedge PCLK); #1;
    issue(0, 1'b1, AddrOe, 32'hffff_ffff);
    push_ok(0, 1'b1, '0);
    @(posedge PCLK);
    @(negedge PCLK);
    check("t1_psel_c1", PSEL, 1);
    check("t1_penable_c1", PENABLE, 0);
    check("t1_busy_c1", busy, 1);
    @(negedge PCLK);
    check("t1_penable_c2", PENABLE, 1);
    check("t1_pwdata", PWDATA, 32'hffff_ffff);
    @(negedge PCLK);
    check("t1_done_c3", done, 2'b01);
    req[0] = 1'b0;
    issue(0, 1'b0, AddrOe, '0);
    push_ok(0, 1'b0, 32'hffff_ffff);
    wait_done(0, 1'b1);

    // 3: m1 read IN with three wait states.
    waits = 3;
    issue(1, 1'b0, AddrIn, '0);
    push_ok(1, 1'b0, InVal);
    watch(1, 1'b0, AddrIn, '0, 4, "t3");
    waits = 0;

    // 2: both held; alternation m0,m1,m0,m1, m1 reads what m0 just wrote.
    issue(0, 1'b1, AddrOut, 32'h0000_0011);
    issue(1, 1'b0, AddrOut, '0);
    push_ok(0, 1'b1, '0);
    push_ok(1, 1'b0, 32'h0000_0011);
    push_ok(0, 1'b1, '0);
    push_ok(1, 1'b0, 32'h0000_0022);
    fork
      begin
        wait_done(0, 1'b0);
        wdata[31:0] = 32'h0000_0022;
        wait_done(0, 1'b1);
      end
      begin
        wait_done(1, 1'b0);
        wait_done(1, 1'b1);
      end
    join

    // 6: request inputs change after grant; latched values must be used.
    waits = 2;
    issue(0, 1'b1, AddrOut, 32'h0000_005a);
    push_ok(0, 1'b1, '0);
    @(posedge PCLK); #1;
    addr[31:0] = AddrOe;
    wdata[31:0] = 32'hdead_beef;
    watch(0, 1'b1, AddrOut, 32'h0000_005a, 3, "t6");
    waits = 0;
    issue(0, 1'b0, AddrOut, '0);
    push_ok(0, 1'b0, 32'h0000_005a);
    wait_done(0, 1'b1);

    // 4: hung slave aborts after 16 ACCESS cycles, next transfer is normal.
    hang = 1'b1;
    issue(0, 1'b0, AddrOe, '0);
    push_err(0);
    watch(0, 1'b0, AddrOe, '0, 16, "t4");
    hang = 1'b0;
    issue(1, 1'b0, AddrOe, '0);
    push_ok(1, 1'b0, 32'hffff_ffff);
    wait_done(1, 1'b1);

    // 5: reset mid-ACCESS kills the transfer silently; first tie afterwards goes to m0.
    hang = 1'b1;
    issue(0, 1'b0, AddrOe, '0);
    for (int k = 0; k < 20 && !PENABLE; k++) @(negedge PCLK);
    #2 PRESETn = 1'b0;
    #1;
    check("t5_psel_async", PSEL, 0);
    check("t5_penable_async", PENABLE, 0);
    check("t5_done_async", done, 0);
    check("t5_err_async", err, 0);
    check("t5_rdata_async", rdata, 0);
    req = '0;
    hang = 1'b0;
    model_rdata = '0;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    issue(0, 1'b0, AddrOe, '0);
    issue(1, 1'b1, AddrOut, 32'h0000_0077);
    push_ok(0, 1'b0, 32'hffff_ffff);
    push_ok(1, 1'b1, '0);
    @(posedge PCLK); #1;
    check("t5_first_grant_paddr", PADDR, AddrOe);
    check("t5_first_grant_pwrite", PWRITE, 0);
    wait_done(0, 1'b1);
    wait_done(1, 1'b1);

    repeat (5) @(negedge PCLK);
    check("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
